// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the RAM port arbiter.
// Also imported by the CPU core and the RAM wrapper.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  localparam int PORT_CPU = 0;
  localparam int PORT_LDR = 1;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory port: request bundle out, grant and read return in.
// Only the loader port drives lock; the CPU port connects through slave_cpu.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

  modport slave_cpu (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_grant_logic.sv
// Combinational grant decision for the two RAM requesters.
// Kept apart from the counters so it can be exercised on its own.
module arb_grant_logic
  import mem_port_arbiter_pkg::*;
#(
  parameter int CW           = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          hold,
  input  logic          req0,
  input  logic          req1,
  input  arb_state_t    state,
  input  logic [CW-1:0] starve_cnt,
  output logic          gnt0,
  output logic          gnt1
);

  logic starved;
  logic in_arb;
  logic lk;
  logic frc;
  logic p0;
  logic p1;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));
  assign in_arb  = !hold && (state == ARB);
  assign lk      = !hold && (state == LOCK1);
  assign frc     = in_arb && starved && req1;
  assign p0      = in_arb && !frc && req0;
  assign p1      = in_arb && !frc && !req0 && req1;

  // In LOCK1 the loader owns the RAM; the CPU only fills idle cycles.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      lk: begin
        gnt1 = req1;
        gnt0 = req0 & ~req1;
      end
      frc, p1: gnt1 = 1'b1;
      p0:      gnt0 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency RAM.
// CPU has priority; the loader gets a starvation guard and bounded bursts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_LOCK     = 8,
  parameter int CW           = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave_cpu m0,
  mem_port_arbiter_if.slave   m1,
  output logic                ram_en,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  input  logic [DW-1:0]       ram_rdata
);

  arb_state_t    state_q;
  arb_state_t    state_n;
  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_n;
  logic [CW-1:0] lock_q;
  logic [CW-1:0] lock_n;
  logic [CW-1:0] lock_inc;
  logic [1:0]    rd_q;
  logic [1:0]    rd_n;
  logic          gnt0;
  logic          gnt1;

  arb_grant_logic #(
    .CW           (CW),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .hold       (reset),
    .req0       (m0.req),
    .req1       (m1.req),
    .state      (state_q),
    .starve_cnt (starve_q),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign lock_inc = lock_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB;
      starve_q <= '0;
      lock_q   <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_n;
      starve_q <= starve_n;
      lock_q   <= lock_n;
      rd_q     <= rd_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    lock_n   = lock_q;
    starve_n = starve_q;
    rd_n     = '0;
    rd_n[PORT_CPU] = gnt0 & ~m0.we;
    rd_n[PORT_LDR] = gnt1 & ~m1.we;
    if (gnt1 || !m1.req) begin
      starve_n = '0;
    end else if (starve_q != CW'(STARVE_LIMIT)) begin
      starve_n = starve_q + CW'(1);
    end
    unique case (state_q)
      ARB: begin
        if (gnt1 && m1.lock) begin
          state_n = LOCK1;
          lock_n  = CW'(1);
        end
      end
      LOCK1: begin
        if (gnt1) begin
          lock_n = lock_inc;
        end
        // Clearing starve_cnt hands the next cycle back to the CPU.
        if (!m1.lock || (gnt1 && lock_inc == CW'(MAX_LOCK))) begin
          state_n  = ARB;
          lock_n   = '0;
          starve_n = '0;
        end
      end
    endcase
  end

  assign ram_en = gnt0 | gnt1;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      gnt1: begin
        ram_we    = m1.we;
        ram_addr  = m1.addr;
        ram_wdata = m1.wdata;
      end
      gnt0: begin
        ram_we    = m0.we;
        ram_addr  = m0.addr;
        ram_wdata = m0.wdata;
      end
      default: ;
    endcase
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rd_q[PORT_CPU];
  assign m1.rvalid = rd_q[PORT_LDR];
  assign m0.rdata  = ram_rdata;
  assign m1.rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed bench for mem_port_arbiter against a cycle-level
// reference model of the arbitration rules and a behavioural RAM.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW   = DEF_AW;
  localparam int DW   = DEF_DW;
  localparam int LIM  = 4;
  localparam int MAXL = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .MAX_LOCK(MAXL), .CW(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] rd_mem(logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else ram_rdata <= rd_mem(ram_addr);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  logic          p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;

  int            waited, used, last, dut_win;
  bit            burst, ev0, ev1;
  logic [DW-1:0] ed;

  task automatic model_reset();
    waited = 0; used = 0; burst = 0; ev0 = 0; ev1 = 0;
  endtask

  task automatic drive();
    m0_if.req = p0_req; m0_if.we = p0_we;
    m0_if.addr = p0_addr; m0_if.wdata = p0_wdata;
    m0_if.lock = 1'b0;
    m1_if.req = p1_req; m1_if.we = p1_we;
    m1_if.addr = p1_addr; m1_if.wdata = p1_wdata;
    m1_if.lock = p1_lock;
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic cycle();
    int w;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    drive();
    #1;
    if (burst) w = p1_req ? 1 : (p0_req ? 0 : -1);
    else if (p1_req && waited >= LIM) w = 1;
    else if (p0_req) w = 0;
    else if (p1_req) w = 1;
    else w = -1;
    we = (w == 1) ? p1_we : (w == 0) ? p0_we : 1'b0;
    a  = (w == 1) ? p1_addr : (w == 0) ? p0_addr : '0;
    d  = (w == 1) ? p1_wdata : (w == 0) ? p0_wdata : '0;
    dut_win = m1_if.gnt ? 1 : (m0_if.gnt ? 0 : -1);
    chk("gnt0", 32'(m0_if.gnt), 32'(w == 0));
    chk("gnt1", 32'(m1_if.gnt), 32'(w == 1));
    chk("ram_en", 32'(ram_en), 32'(w >= 0));
    chk("ram_we", 32'(ram_we), 32'(we));
    chk("ram_addr", 32'(ram_addr), 32'(a));
    chk("ram_wdata", 32'(ram_wdata), 32'(d));
    chk("rvalid0", 32'(m0_if.rvalid), 32'(ev0));
    chk("rvalid1", 32'(m1_if.rvalid), 32'(ev1));
    if (ev0) chk("rdata0", 32'(m0_if.rdata), 32'(ed));
    if (ev1) chk("rdata1", 32'(m1_if.rdata), 32'(ed));
    ev0 = (w == 0) && !p0_we;
    ev1 = (w == 1) && !p1_we;
    ed  = rd_mem(a);
    if (burst) begin
      if (w == 1) used++;
      waited = 0;
      if (!p1_lock || used == MAXL) begin
        burst = 0; used = 0;
      end
    end else if (w == 1) begin
      waited = 0;
      if (p1_lock) begin
        burst = 1; used = 1;
      end
    end else if (p1_req) begin
      waited = (waited < LIM) ? waited + 1 : LIM;
    end else begin
      waited = 0;
    end
    last = w;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    #1;
    chk("rst_gnt0", 32'(m0_if.gnt), 32'(0));
    chk("rst_gnt1", 32'(m1_if.gnt), 32'(0));
    chk("rst_rv0", 32'(m0_if.rvalid), 32'(0));
    chk("rst_rv1", 32'(m1_if.rvalid), 32'(0));
    chk("rst_en", 32'(ram_en), 32'(0));
    chk("rst_we", 32'(ram_we), 32'(0));
    chk("rst_addr", 32'(ram_addr), 32'(0));
    chk("rst_wdata", 32'(ram_wdata), 32'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle();
    p0_req = 0; p1_req = 0; p1_lock = 0;
    cycle();
  endtask

  task automatic set0(logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set1(logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic l);
    p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; p1_lock = l;
  endtask

  int got[14];
  int pat10[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int pat14[14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int g[3];
  int k;

  initial begin
    reset = 1'b1;
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0, 0);
    model_reset();
    last = -1;
    @(negedge clk);
    do_reset();

    // Only m0 reads 0x0010 holding 0x1234.
    set1(1, 1, 16'h0010, 16'h1234, 0);
    cycle();
    set1(0, 0, '0, '0, 0);
    set0(1, 0, 16'h0010, '0);
    cycle();
    chk("t1_gnt", 32'(dut_win), 32'(0));
    chk("t1_rv0", 32'(m0_if.rvalid), 32'(1));
    chk("t1_rdata", 32'(m0_if.rdata), 32'(16'h1234));
    chk("t1_rv1", 32'(m1_if.rvalid), 32'(0));
    idle();

    // Both held high, no lock: starvation guard pattern.
    set0(1, 0, 16'h0001, '0);
    set1(1, 0, 16'h0002, '0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      got[i] = dut_win;
    end
    for (int i = 0; i < 10; i++) chk("starve_pat", 32'(got[i]), 32'(pat10[i]));
    idle();

    // Three locked writes while m0 keeps requesting.
    g = '{-100, -100, -100};
    k = 0;
    set0(1, 0, 16'h0005, '0);
    set1(1, 1, 16'h0020, 16'hBEEF, 1);
    for (int i = 0; i < 20 && k < 3; i++) begin
      cycle();
      if (dut_win == 1) begin
        g[k] = i;
        k++;
        p1_addr = 16'(16'h0020 + k);
        if (k == 2) p1_lock = 0;
        if (k == 3) p1_req = 0;
      end
    end
    chk("lk3_cnt", 32'(k), 32'(3));
    chk("lk3_consec", 32'(g[2] - g[0]), 32'(2));
    cycle();
    chk("lk3_m0", 32'(dut_win), 32'(0));
    set0(1, 0, 16'h0021, '0);
    cycle();
    chk("lk3_rv", 32'(m0_if.rvalid), 32'(1));
    chk("lk3_rd", 32'(m0_if.rdata), 32'(16'hBEEF));
    idle();

    // Lock held with a long queue: burst capped at MAX_LOCK.
    k = 0;
    set0(1, 0, 16'h0007, '0);
    set1(1, 1, 16'h0030, 16'h0000, 1);
    for (int i = 0; i < 14; i++) begin
      cycle();
      got[i] = dut_win;
      if (dut_win == 1) begin
        k++;
        p1_addr = 16'(16'h0030 + k);
        p1_wdata = 16'(k);
      end
    end
    for (int i = 0; i < 14; i++) chk("lock_pat", 32'(got[i]), 32'(pat14[i]));
    idle();

    // Reset right after a locked m1 read grant.
    set0(0, 0, '0, '0);
    set1(1, 0, 16'h0010, '0, 1);
    cycle();
    chk("rs_g1", 32'(dut_win), 32'(1));
    do_reset();
    set0(1, 0, 16'h0010, '0);
    cycle();
    chk("rs_arb", 32'(dut_win), 32'(0));
    chk("rs_rv1", 32'(m1_if.rvalid), 32'(0));
    chk("rs_rv0", 32'(m0_if.rvalid), 32'(1));
    chk("rs_rd0", 32'(m0_if.rdata), 32'(16'h1234));
    idle();

    // Both ports reading every cycle: returns routed to owner.
    set0(1, 0, 16'h0020, '0);
    set1(1, 0, 16'h0030, '0, 0);
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (last == 0) p0_addr = 16'(16'h0020 + (i % 3));
      if (last == 1) p1_addr = 16'(16'h0030 + (i % 8));
    end
    idle();

    // Random traffic; requests held until granted.
    for (int i = 0; i < 800; i++) begin
      if (last == 0 || !p0_req) begin
        p0_req = ($urandom_range(0, 3) != 0);
        p0_we = 1'($urandom_range(0, 1));
        p0_addr = 16'($urandom_range(0, 31));
        p0_wdata = 16'($urandom);
      end
      if (last == 1 || !p1_req) begin
        p1_req = ($urandom_range(0, 2) != 0);
        p1_we = 1'($urandom_range(0, 1));
        p1_addr = 16'($urandom_range(0, 31));
        p1_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) p1_lock = ~p1_lock;
      if (i == 400) do_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
